// File: rtl/layer_sequencer_pkg.sv
// seq_pkg: shared types and constants for the layer sequencer slice.
//   seq_state_t      - sequencer FSM state encoding
//   SEQ_RD_LAT       - weight memory read latency (cycles)
//   SEQ_DEFAULT_LEN  - per-layer row count loaded at reset (default NUM_PE)
//   seq_len_t / seq_perf_t - width helpers for the default configuration
package seq_pkg;

  localparam int unsigned SEQ_NUM_PE      = 32;
  localparam int unsigned SEQ_MAX_LAYERS  = 8;
  localparam int unsigned SEQ_RD_LAT      = 1;
  localparam int unsigned SEQ_DEFAULT_LEN = SEQ_NUM_PE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLR   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_WB    = 3'd5,
    S_FIN   = 3'd6
  } seq_state_t;

  typedef logic [$clog2(SEQ_NUM_PE+1)-1:0] seq_len_t;
  typedef logic [31:0]                     seq_perf_t;

endpackage

// File: rtl/layer_sequencer_len_table.sv
// seq_len_table: MAX_LAYERS x LEN_W register file holding the row count of
// each layer. Writes larger than NUM_PE are clipped to NUM_PE; every entry
// resets to DEFAULT_LEN.
//   clk_i, reset_i - clock, synchronous active-high reset
//   we_i, waddr_i, wdata_i - write port
//   raddr_i, rdata_o       - combinational read port
module seq_len_table import seq_pkg::*; #(
  parameter int unsigned NUM_PE      = SEQ_NUM_PE,
  parameter int unsigned MAX_LAYERS  = SEQ_MAX_LAYERS,
  parameter int unsigned LAYER_W     = $clog2(MAX_LAYERS),
  parameter int unsigned LEN_W       = $clog2(NUM_PE+1),
  parameter int unsigned DEFAULT_LEN = NUM_PE
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               we_i,
  input  logic [LAYER_W-1:0] waddr_i,
  input  logic [LEN_W-1:0]   wdata_i,
  input  logic [LAYER_W-1:0] raddr_i,
  output logic [LEN_W-1:0]   rdata_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NUM_PE);
  localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(DEFAULT_LEN);

  logic [LEN_W-1:0] len_q [MAX_LAYERS];
  logic [LEN_W-1:0] wdata_clip;

  assign wdata_clip = (wdata_i > LEN_MAX) ? LEN_MAX : wdata_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < MAX_LAYERS; i++) len_q[i] <= LEN_RST;
    end else if (we_i && (32'(waddr_i) < MAX_LAYERS)) begin
      len_q[waddr_i] <= wdata_clip;
    end
  end

  assign rdata_o = (32'(raddr_i) < MAX_LAYERS) ? len_q[raddr_i] : '0;

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs the ifmap load and the per-layer clear / stream /
// write-back loop for the shift-register feature memory and PE accelerator.
//   clk, reset            - clock, synchronous active-high reset
//   start, num_layers     - host run request (sampled in IDLE only)
//   cfg_we/layer/len      - per-layer row count writes (dropped while busy)
//   busy, done            - host status; done pulses once per run
//   w_rd_en/w_layer/w_row - weight memory read request
//   mem_addr/we/sel_ifmap - feature memory control
//   acc_en, acc_reset     - accelerator control
//   layer_idx             - current layer
//   perf_cycles           - busy cycle counter (only with SEQ_PERF_CNT_EN)
module layer_sequencer import seq_pkg::*; #(
  parameter int unsigned NUM_PE     = SEQ_NUM_PE,
  parameter int unsigned MAX_LAYERS = SEQ_MAX_LAYERS,
  parameter int unsigned ADDR_W     = $clog2(NUM_PE),
  parameter int unsigned LAYER_W    = $clog2(MAX_LAYERS),
  parameter int unsigned LEN_W      = $clog2(NUM_PE+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LAYER_W:0]   num_layers,
  input  logic               cfg_we,
  input  logic [LAYER_W-1:0] cfg_layer,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               busy,
  output logic               done,
  output logic               w_rd_en,
  output logic [LAYER_W-1:0] w_layer,
  output logic [ADDR_W-1:0]  w_row,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic               mem_sel_ifmap,
  output logic               acc_en,
  output logic               acc_reset,
  output logic [LAYER_W-1:0] layer_idx
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_cycles
`endif
);

  localparam logic [LAYER_W:0] NL_MAX = (LAYER_W+1)'(MAX_LAYERS);

  seq_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  row_q, row_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [LAYER_W:0]   num_q, num_d;
  logic               acc_en_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [LEN_W-1:0]   cur_len;
  logic               last_row, last_layer;

  seq_len_table #(
    .NUM_PE      (NUM_PE),
    .MAX_LAYERS  (MAX_LAYERS),
    .LAYER_W     (LAYER_W),
    .LEN_W       (LEN_W),
    .DEFAULT_LEN (NUM_PE)
  ) u_len_table (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (cfg_we && (state_q == S_IDLE)),
    .waddr_i (cfg_layer),
    .wdata_i (cfg_len),
    .raddr_i (layer_q),
    .rdata_o (cur_len)
  );

  assign last_row   = (LEN_W'(row_q) + LEN_W'(1)) == cur_len;
  assign last_layer = ((LAYER_W+1)'(layer_q) + (LAYER_W+1)'(1)) == num_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    layer_d = layer_q;
    num_d   = num_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = (num_layers > NL_MAX) ? NL_MAX : num_layers;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (num_q == '0) begin
          state_d = S_FIN;
        end else begin
          layer_d = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        row_d   = '0;
        state_d = (cur_len != '0) ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        row_d = row_q + ADDR_W'(1);
        if (last_row) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_WB;
      S_WB: begin
        if (last_layer) begin
          state_d = S_FIN;
        end else begin
          layer_d = layer_q + LAYER_W'(1);
          state_d = S_CLR;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      layer_q    <= '0;
      num_q      <= '0;
      acc_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      layer_q    <= layer_d;
      num_q      <= num_d;
      // One-stage delay matching the weight memory read latency, so the
      // accelerator MACs the row whose weights arrive this cycle.
      acc_en_q   <= w_rd_en;
      mem_addr_q <= w_row;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FIN);
  assign w_rd_en       = (state_q == S_RUN);
  assign w_layer       = layer_q;
  assign w_row         = row_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = (state_q == S_LOAD) || (state_q == S_WB);
  assign mem_sel_ifmap = (state_q == S_LOAD);
  assign acc_en        = acc_en_q;
  assign acc_reset     = (state_q == S_CLR);
  assign layer_idx     = layer_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  // FIN is not counted, so the value seen with done is final and held.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      perf_q <= '0;
    end else if (busy && (state_q != S_FIN) && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] num_layers;
  logic       cfg_we;
  logic [2:0] cfg_layer;
  logic [5:0] cfg_len;
  logic       busy, done, w_rd_en, mem_we, mem_sel_ifmap, acc_en, acc_reset;
  logic [2:0] w_layer, layer_idx;
  logic [4:0] w_row, mem_addr;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  layer_sequencer #(
    .NUM_PE     (32),
    .MAX_LAYERS (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_layers    (num_layers),
    .cfg_we        (cfg_we),
    .cfg_layer     (cfg_layer),
    .cfg_len       (cfg_len),
    .busy          (busy),
    .done          (done),
    .w_rd_en       (w_rd_en),
    .w_layer       (w_layer),
    .w_row         (w_row),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_sel_ifmap (mem_sel_ifmap),
    .acc_en        (acc_en),
    .acc_reset     (acc_reset),
    .layer_idx     (layer_idx)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perf_cycles   (perf_cycles)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int pre_n; int pre_l0; int pre_v0; int pre_l1; int pre_v1;
    int same;  int s_l;    int s_v;    int inj;    int nl;
    int e_cyc; int e_acc;  int e_wb;   int e_clr;
    int e_rd0; int e_rd1;  int e_rd2;
  } vec_t;

  function automatic vec_t mk(input int pre_n, input int pre_l0, input int pre_v0,
                              input int pre_l1, input int pre_v1, input int same,
                              input int s_l, input int s_v, input int inj, input int nl,
                              input int e_cyc, input int e_acc, input int e_wb,
                              input int e_clr, input int e_rd0, input int e_rd1,
                              input int e_rd2);
    vec_t v;
    v.pre_n = pre_n; v.pre_l0 = pre_l0; v.pre_v0 = pre_v0;
    v.pre_l1 = pre_l1; v.pre_v1 = pre_v1; v.same = same;
    v.s_l = s_l; v.s_v = s_v; v.inj = inj; v.nl = nl;
    v.e_cyc = e_cyc; v.e_acc = e_acc; v.e_wb = e_wb; v.e_clr = e_clr;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rd2 = e_rd2;
    return v;
  endfunction

  // per-run observations
  int r_cycles, r_acc, r_wb, r_clr, r_ifmap, r_ifmap_late;
  int r_busy_err, r_row_err, r_align_err, r_busy_after;
  int r_rd [8];
  int r_perf_done, r_perf_after;

  function automatic int zero_vec();
    return int'({busy, done, w_rd_en, w_layer, w_row, mem_addr, mem_we,
                 mem_sel_ifmap, acc_en, acc_reset, layer_idx});
  endfunction

  task automatic cfg_write(input int l, input int v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_layer = 3'(l); cfg_len = 6'(v);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_vec(input int nl, input int same, input int s_l, input int s_v,
                         input int inj);
    int  cyc;
    int  exp_row;
    int  prev_row;
    logic prev_rd;
    for (int i = 0; i < 8; i++) r_rd[i] = 0;
    r_acc = 0; r_wb = 0; r_clr = 0; r_ifmap = 0; r_ifmap_late = 0;
    r_busy_err = 0; r_row_err = 0; r_align_err = 0;
    r_cycles = -1; r_perf_done = -1; r_perf_after = -1;
    @(negedge clk);
    start = 1'b1; num_layers = 4'(nl);
    if (same != 0) begin
      cfg_we = 1'b1; cfg_layer = 3'(s_l); cfg_len = 6'(s_v);
    end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    prev_rd = 1'b0; prev_row = 0; exp_row = 0;
    cyc = 1;
    while (cyc <= 1000) begin
      if (inj != 0 && cyc == inj) begin
        start = 1'b1; num_layers = 4'd3; cfg_we = 1'b1; cfg_layer = 3'd0; cfg_len = 6'd7;
      end else if (inj != 0 && cyc == inj + 1) begin
        start = 1'b0; cfg_we = 1'b0;
      end
      if (!busy) r_busy_err++;
      if (mem_we && mem_sel_ifmap) begin
        r_ifmap++;
        if (cyc != 1) r_ifmap_late++;
      end
      if (mem_we && !mem_sel_ifmap) r_wb++;
      if (acc_reset) begin r_clr++; exp_row = 0; end
      if (w_rd_en) begin
        r_rd[w_layer]++;
        if (int'(w_row) != exp_row || w_layer != layer_idx) r_row_err++;
        exp_row++;
      end
      if (acc_en) r_acc++;
      if (acc_en != prev_rd || (acc_en && int'(mem_addr) != prev_row)) r_align_err++;
      prev_rd = w_rd_en; prev_row = int'(w_row);
      if (done) begin
        r_cycles = cyc;
`ifdef SEQ_PERF_CNT_EN
        r_perf_done = int'(perf_cycles);
`endif
        break;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    r_busy_after = int'(busy | done);
`ifdef SEQ_PERF_CNT_EN
    r_perf_after = int'(perf_cycles);
`endif
  endtask

  vec_t vecs [9];

  initial begin
    int ok;
    // table state carries over between vectors
    vecs[0] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  4, 142, 128, 4, 4, 32, 32, 32);
    vecs[1] = mk(2, 0, 10, 1, 20, 0, 0, 0, 0,  2,  38,  30, 2, 2, 10, 20,  0);
    vecs[2] = mk(1, 0, 0,  0, 0,  0, 0, 0, 0,  1,   5,   0, 1, 1,  0,  0,  0);
    vecs[3] = mk(1, 2, 40, 0, 0,  0, 0, 0, 0,  0,   2,   0, 0, 0,  0,  0,  0);
    vecs[4] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  3,  63,  52, 3, 3,  0, 20, 32);
    vecs[5] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 15, 238, 212, 8, 8,  0, 20, 32);
    vecs[6] = mk(0, 0, 0,  0, 0,  1, 0, 5, 0,  1,  10,   5, 1, 1,  5,  0,  0);
    vecs[7] = mk(0, 0, 0,  0, 0,  0, 0, 0, 4,  1,  10,   5, 1, 1,  5,  0,  0);
    vecs[8] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  1,  10,   5, 1, 1,  5,  0,  0);

    reset = 1'b1; start = 1'b0; num_layers = '0;
    cfg_we = 1'b0; cfg_layer = '0; cfg_len = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", zero_vec(), 0);
`ifdef SEQ_PERF_CNT_EN
    check("reset_perf", int'(perf_cycles), 0);
`endif
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].pre_n > 0) cfg_write(vecs[v].pre_l0, vecs[v].pre_v0);
      if (vecs[v].pre_n > 1) cfg_write(vecs[v].pre_l1, vecs[v].pre_v1);
      run_vec(vecs[v].nl, vecs[v].same, vecs[v].s_l, vecs[v].s_v, vecs[v].inj);
      check($sformatf("v%0d_done_cycle", v), r_cycles, vecs[v].e_cyc);
      check($sformatf("v%0d_acc_en_cnt", v), r_acc, vecs[v].e_acc);
      check($sformatf("v%0d_wb_cnt", v), r_wb, vecs[v].e_wb);
      check($sformatf("v%0d_acc_reset_cnt", v), r_clr, vecs[v].e_clr);
      check($sformatf("v%0d_rd_layer0", v), r_rd[0], vecs[v].e_rd0);
      check($sformatf("v%0d_rd_layer1", v), r_rd[1], vecs[v].e_rd1);
      check($sformatf("v%0d_rd_layer2", v), r_rd[2], vecs[v].e_rd2);
      check($sformatf("v%0d_ifmap_wr", v), r_ifmap, 1);
      check($sformatf("v%0d_ifmap_late", v), r_ifmap_late, 0);
      check($sformatf("v%0d_busy_gap", v), r_busy_err, 0);
      check($sformatf("v%0d_row_seq", v), r_row_err, 0);
      check($sformatf("v%0d_align", v), r_align_err, 0);
      check($sformatf("v%0d_idle_after", v), r_busy_after, 0);
`ifdef SEQ_PERF_CNT_EN
      check($sformatf("v%0d_perf_done", v), r_perf_done, vecs[v].e_cyc - 1);
      check($sformatf("v%0d_perf_held", v), r_perf_after, vecs[v].e_cyc - 1);
`endif
    end

    // reset in the middle of layer 1's RUN: immediate abort, table restored
    cfg_write(0, 9);
    @(negedge clk);
    start = 1'b1; num_layers = 4'd2;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      if (w_rd_en && layer_idx == 3'd1 && w_row == 5'd5) begin ok = 1; break; end
      @(negedge clk);
    end
    check("reach_l1_row5", ok, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs", zero_vec(), 0);
    reset = 1'b0;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) ok++;
    end
    check("no_done_after_abort", ok, 0);
    run_vec(1, 0, 0, 0, 0);
    check("table_restored_rd0", r_rd[0], 32);
    check("table_restored_cycles", r_cycles, 37);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Parametrised hardware replacement for the hand-written layer loop that currently drives the shift-register feature memory and the PE accelerator from software/bench.
- Loads the input fmap, then for each of up to MAX_LAYERS layers: clears accumulators, streams weight rows, and writes the layer result back into feature memory.
- Sits between a host start/done handshake and the shift_reg_mem, weight memory and accelerator.
- Generalises the fixed 32-row, 4-layer flow to a configurable PE count, layer count and per-layer input length.

Parameters:
NUM_PE, 32, accelerator width (output channels) and maximum rows per layer
MAX_LAYERS, 8, depth of the per-layer length table
ADDR_W, $clog2(NUM_PE), feature-memory / weight-row address width
LAYER_W, $clog2(MAX_LAYERS), layer index width
LEN_W, $clog2(NUM_PE+1), row-count width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request run; sampled only in IDLE
num_layers  in  LAYER_W+1  layers to run; sampled with start
cfg_we  in  1  write per-layer length; ignored while busy
cfg_layer  in  LAYER_W  table index for cfg_we
cfg_len  in  LEN_W  rows for that layer; values >NUM_PE are clipped to NUM_PE
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at end of run
w_rd_en  out  1  weight memory read request
w_layer  out  LAYER_W  weight memory layer address
w_row  out  ADDR_W  weight memory row address
mem_addr  out  ADDR_W  feature memory read address, aligned to acc_en
mem_we  out  1  feature memory write enable
mem_sel_ifmap  out  1  1 = write external ifmap, 0 = write accelerator output
acc_en  out  1  accelerator enable (MAC this cycle)
acc_reset  out  1  accelerator accumulator clear
layer_idx  out  LAYER_W  current layer

Behaviour:
- Reset:
  - All outputs 0; FSM to IDLE; counters 0.
  - Length table reset to NUM_PE for every entry.
  - Reset mid-run aborts immediately; no done pulse.
- FSM states: IDLE, LOAD, CLR, RUN, DRAIN, WB, FIN.
- IDLE:
  - start=1 latches num_layers, sets busy, goes to LOAD.
  - start in any other state is ignored.
- LOAD (1 cycle): mem_we=1, mem_sel_ifmap=1.
  - num_layers==0 goes to FIN; otherwise layer=0 and go to CLR.
- CLR (1 cycle): acc_reset=1, row=0.
  - Go to RUN if len[layer]>0, else go to DRAIN.
- RUN (len cycles):
  - w_rd_en=1, w_row=row, w_layer=layer; row increments each cycle.
  - Weight memory has 1-cycle read latency, so acc_en and mem_addr are w_rd_en and w_row delayed one cycle.
  - Exit to DRAIN after row==len-1.
- DRAIN (1 cycle): last acc_en beat; no new read.
- WB (1 cycle): mem_we=1, mem_sel_ifmap=0.
  - Last layer (layer==num_layers-1) goes to FIN; otherwise layer++ and go to CLR.
- FIN (1 cycle): done=1, busy=0 on the next cycle, go to IDLE.
- Timing:
  - A layer takes len+3 cycles.
  - A run takes 1 + Σ(len_i+3) + 1 cycles.
- num_layers > MAX_LAYERS is clamped to MAX_LAYERS.
- A zero-length layer writes back the cleared accumulator (all zeros).
- cfg_we during busy is dropped. cfg_we and start in the same IDLE cycle: the config write lands first and applies to that run.
- layer_idx is valid while busy and holds its last value in IDLE.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined:
  - Adds output perf_cycles[31:0], counting cycles with busy=1.
  - Cleared on run start; frozen after FIN until the next start; saturates at all ones.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package seq_pkg holds:
  - state enum seq_state_t;
  - localparams SEQ_RD_LAT=1 and SEQ_DEFAULT_LEN=NUM_PE;
  - width helper typedefs.
- Sub-module seq_len_table: MAX_LAYERS×LEN_W register file with the clip-on-write logic, a write port and a combinational read port.
- FSM, row counter and 1-cycle align pipeline stay in layer_sequencer.

Test Plan:
1. Reset, default table, num_layers=4, NUM_PE=32, start pulse -> LOAD 1 cycle after acceptance; done 142 cycles after start sampled; 4 WB pulses with mem_sel_ifmap=0; exactly 128 acc_en cycles.
2. cfg_len layer0=10, layer1=20, num_layers=2 -> 10 then 20 w_rd_en cycles; acc_en trails w_rd_en by exactly 1 cycle, including w_row sequence 0..9 on mem_addr; done at cycle 1+13+23+1=38.
3. cfg_len=0 for layer0, num_layers=1 -> CLR, DRAIN, WB with no acc_en; done at cycle 5.
4. cfg_len=40 -> stored as 32; start with num_layers=0 -> LOAD then done at cycle 2; no acc_reset.
5. start and cfg_we asserted while busy -> both ignored (table readback unchanged, no restart); assert reset in mid-RUN of layer 1 -> all outputs 0 next cycle, no done, table back to 32.
6. With SEQ_PERF_CNT_EN, scenario 1 -> perf_cycles=141 after done and held until the next start.
